// File: rtl/buffer_reader.sv
// Read-side initiator for the buffer FIFO: runs the re/r_ack four-phase handshake,
// holds one captured word for a valid/ready consumer and flags stalled handshakes.
module buffer_reader #(
  parameter int unsigned DATA_L = 16,
  parameter int unsigned TO_L   = 8,
  parameter int unsigned CNT_L  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic              buf_avail_i,
  output logic              buf_re_o,
  input  logic              buf_r_ack_i,
  input  logic [DATA_L-1:0] buf_dout_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_L-1:0] out_data_o,
  output logic [CNT_L-1:0]  rd_count_o,
  output logic              timeout_err_o,
  input  logic              err_clr_i
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StDrop = 2'd2;

  localparam logic [TO_L-1:0]  ToLimit = {TO_L{1'b1}};
  localparam logic [TO_L-1:0]  ToOne   = TO_L'(1);
  localparam logic [CNT_L-1:0] CntOne  = CNT_L'(1);

  logic              avail_meta_q, avail_s_q;
  logic              ack_meta_q, ack_s_q;
  logic [1:0]        state_q, state_d;
  logic              re_q, re_d;
  logic [TO_L-1:0]   to_q, to_d, to_inc;
  logic              valid_q, valid_d;
  logic [DATA_L-1:0] data_q, data_d;
  logic [CNT_L-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              timeout;

  assign to_inc = to_q + ToOne;

  always_comb begin
    state_d = state_q;
    re_d    = re_q;
    to_d    = to_q;
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    timeout = 1'b0;

    // A capture only happens in StReq, which is never entered with a word held,
    // so acceptance and capture cannot collide.
    if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
      cnt_d   = cnt_q + CntOne;
    end

    case (state_q)
      StIdle: begin
        re_d = 1'b0;
        to_d = '0;
        if (enable_i && avail_s_q && !ack_s_q && !valid_q) begin
          state_d = StReq;
          re_d    = 1'b1;
        end
      end
      StReq: begin
        if (ack_s_q) begin
          data_d  = buf_dout_i;
          valid_d = 1'b1;
          re_d    = 1'b0;
          state_d = StDrop;
          to_d    = '0;
        end else if (to_inc == ToLimit) begin
          timeout = 1'b1;
          re_d    = 1'b0;
          state_d = StDrop;
          to_d    = '0;
        end else begin
          to_d = to_inc;
        end
      end
      StDrop: begin
        re_d = 1'b0;
        if (!ack_s_q) begin
          state_d = StIdle;
          to_d    = '0;
        end else if (to_q != ToLimit) begin
          // Saturate at the limit so a stuck ack flags once, not every wrap.
          to_d = to_inc;
          if (to_inc == ToLimit) timeout = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        re_d    = 1'b0;
        to_d    = '0;
      end
    endcase

    if (timeout)        err_d = 1'b1;
    else if (err_clr_i) err_d = 1'b0;
    else                err_d = err_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      avail_meta_q <= 1'b0;
      avail_s_q    <= 1'b0;
      ack_meta_q   <= 1'b0;
      ack_s_q      <= 1'b0;
      state_q      <= StIdle;
      re_q         <= 1'b0;
      to_q         <= '0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      avail_meta_q <= buf_avail_i;
      avail_s_q    <= avail_meta_q;
      ack_meta_q   <= buf_r_ack_i;
      ack_s_q      <= ack_meta_q;
      state_q      <= state_d;
      re_q         <= re_d;
      to_q         <= to_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  assign buf_re_o      = re_q;
  assign out_valid_o   = valid_q;
  assign out_data_o    = data_q;
  assign rd_count_o    = cnt_q;
  assign timeout_err_o = err_q;

endmodule

// File: tb/tb_buffer_reader.sv
// Bench for buffer_reader: a queue-backed buffer model on the read side and a
// scoreboard monitor on the downstream valid/ready port.
module tb_buffer_reader;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        buf_avail;
  logic        buf_re;
  logic        buf_r_ack;
  logic [15:0] buf_dout;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  rd_count;
  logic        timeout_err;
  logic        err_clr;

  buffer_reader #(
    .DATA_L(16),
    .TO_L  (4),
    .CNT_L (4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .enable_i     (enable),
    .buf_avail_i  (buf_avail),
    .buf_re_o     (buf_re),
    .buf_r_ack_i  (buf_r_ack),
    .buf_dout_i   (buf_dout),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .rd_count_o   (rd_count),
    .timeout_err_o(timeout_err),
    .err_clr_i    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] fifo_q[$];
  logic [15:0] exp_q[$];
  bit          stuck_ack = 1'b0;
  int          re_rises  = 0;
  logic        re_prev   = 1'b0;
  int          stab_err  = 0;
  logic        prev_valid = 1'b0;
  logic [15:0] prev_data  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Buffer model: pops on a new request, holds ack until re falls.
  initial begin
    buf_avail = 1'b0;
    buf_r_ack = 1'b0;
    buf_dout  = '0;
  end
  always @(posedge clk) begin
    if (buf_re && !re_prev) begin
      re_rises++;
      check("no_read_when_empty", {31'd0, fifo_q.size() != 0}, 32'd1);
    end
    re_prev = buf_re;
    if (buf_re && !buf_r_ack && !stuck_ack && fifo_q.size() != 0) begin
      buf_dout  <= fifo_q.pop_front();
      buf_r_ack <= 1'b1;
    end else if (!buf_re && buf_r_ack) begin
      buf_r_ack <= 1'b0;
    end
    buf_avail <= (fifo_q.size() != 0);
  end

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && out_valid && prev_valid && out_data != prev_data) stab_err++;
    prev_valid = out_valid;
    prev_data  = out_data;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_word: got 0x%0h expected none", out_data);
      end else begin
        check("word", {16'd0, out_data}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load(input logic [15:0] w, input bit expect_it);
    fifo_q.push_back(w);
    if (expect_it) exp_q.push_back(w);
  endtask

  task automatic wait_re(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (buf_re) begin
        ok = 1'b1;
        break;
      end
    end
    check("re_rise", {31'd0, ok}, 32'd1);
  endtask

  task automatic drain(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain", {31'd0, ok}, 32'd1);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  int r0;
  int hi_cnt;
  int n;

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    #12;
    check("rst_re", {31'd0, buf_re}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {16'd0, out_data}, 32'd0);
    check("rst_count", {28'd0, rd_count}, 32'd0);
    check("rst_err", {31'd0, timeout_err}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Empty buffer: never request.
    enable    = 1'b1;
    out_ready = 1'b1;
    hi_cnt    = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (buf_re) hi_cnt++;
    end
    check("empty_no_re", hi_cnt, 0);
    check("empty_no_valid", {31'd0, out_valid}, 32'd0);

    // Three words in order.
    load(16'h1111, 1'b1);
    load(16'h2222, 1'b1);
    load(16'h3333, 1'b1);
    drain(100);
    repeat (10) @(posedge clk);
    #1 check("t1_count", {28'd0, rd_count}, 32'd3);

    // Downstream stall: one read only, held word stable.
    out_ready = 1'b0;
    r0 = re_rises;
    load(16'h4444, 1'b1);
    load(16'h5555, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    check("stall_reads", re_rises - r0, 1);
    check("stall_valid", {31'd0, out_valid}, 32'd1);
    check("stall_data", {16'd0, out_data}, 32'h4444);
    out_ready = 1'b1;
    drain(100);
    check("stall_after_reads", re_rises - r0, 2);
    check("data_stable", stab_err, 0);
    check("t3_count", {28'd0, rd_count}, 32'd5);

    // Ack never rises: timeout after 15 cycles in REQ.
    stuck_ack = 1'b1;
    load(16'h7777, 1'b0);
    wait_re(20);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      n++;
      if (timeout_err) break;
    end
    enable = 1'b0;
    check("to_cycles", n, 15);
    check("to_re_low", {31'd0, buf_re}, 32'd0);
    check("to_valid", {31'd0, out_valid}, 32'd0);
    repeat (5) @(posedge clk);
    #1 check("to_sticky", {31'd0, timeout_err}, 32'd1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("to_cleared", {31'd0, timeout_err}, 32'd0);
    fifo_q.delete();
    stuck_ack = 1'b0;
    repeat (4) @(posedge clk);
    #1 enable = 1'b1;

    // Reset mid-handshake: first word lost, next read normal.
    load(16'hDEAD, 1'b0);
    load(16'hBEEF, 1'b1);
    wait_re(20);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_re", {31'd0, buf_re}, 32'd0);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_data", {16'd0, out_data}, 32'd0);
    check("mid_rst_count", {28'd0, rd_count}, 32'd0);
    check("mid_rst_err", {31'd0, timeout_err}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    drain(100);
    check("t5_count", {28'd0, rd_count}, 32'd1);

    // 18 words: counter wraps to 2.
    pulse_reset();
    for (int i = 0; i < 18; i++) load(16'hA000 + 16'(i), 1'b1);
    drain(400);
    check("wrap_count", {28'd0, rd_count}, 32'd2);
    check("wrap_err", {31'd0, timeout_err}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
